dnn_param_streamer: RTL and testbench

Parameter-side transmitter for the 2-layer DNN accelerator's serial parameter load port. It holds a 23-byte parameter image written by the host: 12 layer-1 weights, 6 layer-2 weights, then bias bytes. On command it pulses `load_params`, streams the image byte-by-byte with `param_valid`, and waits for the accelerator's `params_loaded` acknowledge. It sits between the host configuration bus and the accelerator, replacing hand-driven parameter sequencing.

---
 rtl/dnn_param_if.sv | 40 ++++
 rtl/dnn_param_streamer.sv | 182 ++++++++++++++++++
 tb/tb_dnn_param_streamer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dnn_param_if.sv
// -----------------------------------------------------------------------------
// dnn_param_if
// Bundles the host configuration bus, the load command/status handshake and
// the serial parameter stream between the host/accelerator side and
// dnn_param_streamer.
//   cfg_we/cfg_addr/cfg_wdata : host image write port
//   cfg_rdata                 : combinational image readback
//   go/busy/done/err          : load command and status
//   load_params/param_valid/param_data/param_addr : stream to accelerator
//   params_loaded             : accelerator acknowledge (level)
// slave  : the streamer itself
// master : host + accelerator side (testbench)
// -----------------------------------------------------------------------------
interface dnn_param_if;
    logic       cfg_we;
    logic [4:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       go;
    logic       busy;
    logic       done;
    logic       err;
    logic       load_params;
    logic       param_valid;
    logic [7:0] param_data;
    logic [3:0] param_addr;
    logic       params_loaded;

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, go, params_loaded,
        output cfg_rdata, busy, done, err, load_params,
               param_valid, param_data, param_addr
    );

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, go, params_loaded,
        input  cfg_rdata, busy, done, err, load_params,
               param_valid, param_data, param_addr
    );
endinterface

// File: rtl/dnn_param_streamer.sv
// -----------------------------------------------------------------------------
// dnn_param_streamer
// Holds a NUM_BYTES parameter image written by the host and, on go, pulses
// load_params, streams the image byte by byte (optionally with GAP_CYCLES idle
// cycles between bytes) and waits up to TIMEOUT for params_loaded.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (also clears the image)
//   bus   : dnn_param_if.slave, see the interface for signal list
// NUM_BYTES must not exceed 31 (5-bit cfg_addr, index compare in 6 bits).
// -----------------------------------------------------------------------------
module dnn_param_streamer #(
    parameter int NUM_BYTES  = 23,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    dnn_param_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SEND,
        S_GAP,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT);
    localparam logic [4:0]    LAST_IDX = 5'(NUM_BYTES - 1);

    state_t        r_state;
    logic [7:0]    r_image [NUM_BYTES];
    logic [4:0]    r_idx;
    logic [GW-1:0] r_gcnt;
    logic [TW-1:0] r_tcnt;
    logic          r_ack;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_load;
    logic          r_pvalid;
    logic [7:0]    r_pdata;
    logic [3:0]    r_paddr;

    logic          w_addr_ok;
    logic          w_wr_en;
    logic [4:0]    w_idx_inc;

    assign w_addr_ok = ({1'b0, bus.cfg_addr} < 6'(NUM_BYTES));
    assign w_wr_en   = bus.cfg_we & ~r_busy & w_addr_ok;
    assign w_idx_inc = r_idx + 5'd1;

    assign bus.cfg_rdata   = w_addr_ok ? r_image[bus.cfg_addr] : 8'h00;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.load_params = r_load;
    assign bus.param_valid = r_pvalid;
    assign bus.param_data  = r_pdata;
    assign bus.param_addr  = r_paddr;

    // Host writes are blocked while busy; a write on the go-accepting edge
    // still lands because busy is only registered at that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                r_image[i] <= 8'h00;
            end
        end else if (w_wr_en) begin
            r_image[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    // Outputs are computed for the state being entered, so they are valid in
    // the same cycle as that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= 5'd0;
            r_gcnt   <= '0;
            r_tcnt   <= '0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_load   <= 1'b0;
            r_pvalid <= 1'b0;
            r_pdata  <= 8'h00;
            r_paddr  <= 4'h0;
        end else begin
            r_done <= 1'b0;
            r_load <= 1'b0;
            // Acknowledge is captured only while waiting, so an early or
            // permanently high params_loaded cannot cut the stream short.
            r_ack  <= (r_state == S_WAIT) & bus.params_loaded;

            case (r_state)
                S_IDLE: begin
                    if (bus.go) begin
                        r_state <= S_ARM;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_load  <= 1'b1;
                        r_idx   <= 5'd0;
                    end
                end

                S_ARM: begin
                    r_state  <= S_SEND;
                    r_pvalid <= 1'b1;
                    r_pdata  <= r_image[r_idx];
                    r_paddr  <= r_idx[3:0];
                end

                S_SEND: begin
                    if (r_idx == LAST_IDX) begin
                        r_state  <= S_WAIT;
                        r_tcnt   <= '0;
                        r_pvalid <= 1'b0;
                        r_pdata  <= 8'h00;
                        r_paddr  <= 4'h0;
                    end else if (GAP_CYCLES == 0) begin
                        r_idx    <= w_idx_inc;
                        r_pvalid <= 1'b1;
                        r_pdata  <= r_image[w_idx_inc];
                        r_paddr  <= w_idx_inc[3:0];
                    end else begin
                        r_state  <= S_GAP;
                        r_gcnt   <= GAP_LOAD;
                        r_pvalid <= 1'b0;
                        r_pdata  <= 8'h00;
                        r_paddr  <= 4'h0;
                    end
                end

                S_GAP: begin
                    if (r_gcnt == '0) begin
                        r_state  <= S_SEND;
                        r_idx    <= w_idx_inc;
                        r_pvalid <= 1'b1;
                        r_pdata  <= r_image[w_idx_inc];
                        r_paddr  <= w_idx_inc[3:0];
                    end else begin
                        r_gcnt <= r_gcnt - 1'b1;
                    end
                end

                // The acknowledge goes through r_ack, so both the ack and the
                // timeout paths resolve one edge after the level is seen.
                S_WAIT: begin
                    if (r_ack) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_tcnt == TO_LIM) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_param_streamer.sv
module tb_dnn_param_streamer;

    localparam int N = 23;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       t_we;
    logic [1:0] t_wmask;
    logic [4:0] t_addr;
    logic [7:0] t_wdata;
    logic       t_go;
    logic       t_ack;
    int         sel;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_img [N];
    int         m_err [2];

    dnn_param_if if0();
    dnn_param_if if1();

    dnn_param_streamer #(.NUM_BYTES(23), .GAP_CYCLES(0), .TIMEOUT(64)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    dnn_param_streamer #(.NUM_BYTES(23), .GAP_CYCLES(2), .TIMEOUT(8)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    assign if0.cfg_we        = t_we & t_wmask[0];
    assign if1.cfg_we        = t_we & t_wmask[1];
    assign if0.cfg_addr      = t_addr;
    assign if1.cfg_addr      = t_addr;
    assign if0.cfg_wdata     = t_wdata;
    assign if1.cfg_wdata     = t_wdata;
    assign if0.go            = t_go & (sel == 0);
    assign if1.go            = t_go & (sel == 1);
    assign if0.params_loaded = t_ack & (sel == 0);
    assign if1.params_loaded = t_ack & (sel == 1);

    logic       o_busy, o_done, o_err, o_lp, o_pv;
    logic [7:0] o_pdata, o_rdata;
    logic [3:0] o_paddr;

    always_comb begin
        o_busy  = if0.busy;
        o_done  = if0.done;
        o_err   = if0.err;
        o_lp    = if0.load_params;
        o_pv    = if0.param_valid;
        o_pdata = if0.param_data;
        o_paddr = if0.param_addr;
        o_rdata = if0.cfg_rdata;
        if (sel == 1) begin
            o_busy  = if1.busy;
            o_done  = if1.done;
            o_err   = if1.err;
            o_lp    = if1.load_params;
            o_pv    = if1.param_valid;
            o_pdata = if1.param_data;
            o_paddr = if1.param_addr;
            o_rdata = if1.cfg_rdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  32'(o_busy),  0);
        chk({tag, "_done"},  32'(o_done),  0);
        chk({tag, "_lp"},    32'(o_lp),    0);
        chk({tag, "_pv"},    32'(o_pv),    0);
        chk({tag, "_pdata"}, 32'(o_pdata), 0);
        chk({tag, "_paddr"}, 32'(o_paddr), 0);
    endtask

    task automatic check_readback(input string tag);
        for (int a = 0; a < 32; a++) begin
            t_addr = 5'(a);
            #1;
            chk(tag, 32'(o_rdata), (a < N) ? 32'(m_img[a]) : 32'd0);
        end
    endtask

    task automatic write_image(input int pattern);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            t_we    = 1'b1;
            t_wmask = 2'b11;
            t_addr  = 5'(i);
            t_wdata = (pattern == 0) ? 8'(8'h10 + i) : 8'($urandom_range(0, 255));
            m_img[i] = t_wdata;
        end
        @(negedge clk);
        t_we = 1'b0;
    endtask

    // mode 0: ack one cycle after the last byte, 1: never ack, 2: ack held high
    task automatic run_load(input int s, input int mode, input int gap, input int tmo,
                            input bit cowrite, input bit poke, input int abort_c);
        int  wait_edge, done_edge, seen, exp_err, k;
        bit  pend, vld;
        sel       = s;
        wait_edge = 1 + (N - 1) * (gap + 1) + 1;
        done_edge = (mode == 1) ? wait_edge + tmo + 1 : wait_edge + 2;
        exp_err   = (mode == 1) ? 1 : 0;
        seen      = 0;
        pend      = 1'b0;
        t_ack     = (mode == 2);
        @(negedge clk);
        chk("pre_busy", 32'(o_busy), 0);
        chk("pre_err",  32'(o_err),  32'(m_err[s]));
        t_go = 1'b1;
        if (cowrite) begin
            t_we    = 1'b1;
            t_wmask = 2'b11;
            t_addr  = 5'd5;
            t_wdata = 8'hAB;
            m_img[5] = 8'hAB;
        end
        for (int c = 0; c <= done_edge + 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                t_go = 1'b0;
                t_we = 1'b0;
            end
            if (poke && c == 5) begin
                t_go    = 1'b1;
                t_we    = 1'b1;
                t_wmask = (s == 0) ? 2'b01 : 2'b10;
                t_addr  = 5'd5;
                t_wdata = 8'hCD;
            end
            if (poke && c == 6) begin
                t_go    = 1'b0;
                t_we    = 1'b0;
                t_wmask = 2'b11;
            end
            k   = (c - 1) / (gap + 1);
            vld = (c >= 1) && ((c - 1) % (gap + 1) == 0) && (k < N);
            if (c == abort_c) begin
                chk("abort_pre_pv",   32'(o_pv),    1);
                chk("abort_pre_data", 32'(o_pdata), 32'(m_img[k]));
                #1 rst_n = 1'b0;
                #1;
                chk("abort_busy", 32'(o_busy), 0);
                chk("abort_pv",   32'(o_pv),   0);
                chk("abort_err",  32'(o_err),  0);
                chk("abort_lp",   32'(o_lp),   0);
                for (int i = 0; i < N; i++) m_img[i] = 8'h00;
                m_err[0] = 0;
                m_err[1] = 0;
                t_ack    = 1'b0;
                return;
            end
            chk("lp",    32'(o_lp),    (c == 0) ? 1 : 0);
            chk("pv",    32'(o_pv),    vld ? 1 : 0);
            chk("pdata", 32'(o_pdata), vld ? 32'(m_img[k]) : 0);
            chk("paddr", 32'(o_paddr), vld ? (k % 16) : 0);
            chk("busy",  32'(o_busy),  (c < done_edge) ? 1 : 0);
            chk("done",  32'(o_done),  (c == done_edge) ? 1 : 0);
            chk("err",   32'(o_err),   (c >= done_edge) ? exp_err : 0);
            if (mode == 0) begin
                if (pend) t_ack = 1'b1;
                if (o_pv) seen++;
                pend = (seen == N) && !t_ack;
            end
            if (c == done_edge) t_ack = 1'b0;
        end
        t_ack    = 1'b0;
        m_err[s] = exp_err;
    endtask

    initial begin
        rst_n   = 1'b0;
        t_we    = 1'b0;
        t_wmask = 2'b11;
        t_addr  = 5'd0;
        t_wdata = 8'h00;
        t_go    = 1'b0;
        t_ack   = 1'b0;
        sel     = 0;
        m_err[0] = 0;
        m_err[1] = 0;
        for (int i = 0; i < N; i++) m_img[i] = 8'h00;

        // Reset state on both instances
        repeat (3) @(negedge clk);
        sel = 0;
        chk_idle_outputs("rst0");
        chk("rst0_err", 32'(o_err), 0);
        sel = 1;
        chk_idle_outputs("rst1");
        chk("rst1_err", 32'(o_err), 0);
        check_readback("rst_rdata");
        rst_n = 1'b1;

        // Incrementing image, back-to-back stream with ack
        write_image(0);
        sel = 0;
        check_readback("img_rdata");
        run_load(0, 0, 0, 64, 1'b0, 1'b0, -1);

        // Same image with two gap cycles
        run_load(1, 0, 2, 8, 1'b0, 1'b0, -1);

        // Random image, timeout then successful load clears err
        write_image(1);
        run_load(1, 1, 2, 8, 1'b0, 1'b0, -1);
        run_load(1, 0, 2, 8, 1'b0, 1'b0, -1);
        run_load(0, 1, 0, 64, 1'b0, 1'b0, -1);
        run_load(0, 0, 0, 64, 1'b0, 1'b0, -1);

        // Write on go edge, write and go while busy
        run_load(0, 0, 0, 64, 1'b1, 1'b1, -1);
        sel = 0;
        check_readback("busy_wr_rdata0");
        sel = 1;
        check_readback("busy_wr_rdata1");

        // Acknowledge held high from the start
        write_image(1);
        run_load(0, 2, 0, 64, 1'b0, 1'b0, -1);
        run_load(1, 2, 2, 8, 1'b0, 1'b0, -1);

        // Reset during byte 10, then stream the cleared image
        run_load(0, 0, 0, 64, 1'b0, 1'b0, 11);
        @(negedge clk);
        rst_n = 1'b1;
        sel = 0;
        check_readback("post_rst_rdata0");
        sel = 1;
        check_readback("post_rst_rdata1");
        run_load(0, 0, 0, 64, 1'b0, 1'b0, -1);
        run_load(1, 0, 2, 8, 1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
